lin_frame_tx: RTL and testbench

- Parametrised LIN commander frame transmitter, successor to the fixed 2-byte header/response generator in lin_top.
- Serialises a complete frame on one wire: break, sync, protected ID, 1–8 data bytes and checksum.
- Checksum mode (classic/enhanced) is selectable per frame; a start/busy/done handshake sequences frames.
- Sits between the LIN scheduler and the transceiver TX pin.

---
 rtl/lin_pkg.sv | 44 ++++
 rtl/lin_bit_tick.sv | 38 +++
 rtl/lin_frame_tx.sv | 174 +++++++++++++++++
 tb/tb_lin_frame_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lin_pkg.sv
// -----------------------------------------------------------------------------
// lin_pkg
// Shared types, constants and helper functions for the LIN commander frame
// transmitter.
//   lin_tx_state_t  : frame sequencer states
//   SYNC_BYTE       : fixed sync field value
//   DIAG_ID_*       : diagnostic frame identifiers that always use classic sums
//   lin_calc_pid    : 6-bit identifier -> 8-bit protected identifier
//   lin_chk_add     : one step of the LIN carry-wrapped checksum sum
// -----------------------------------------------------------------------------
package lin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        DELIM,
        SYNC,
        PID,
        DATA,
        CHK
    } lin_tx_state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'h55;
    localparam logic [5:0] DIAG_ID_MREQ  = 6'h3C;
    localparam logic [5:0] DIAG_ID_SRESP = 6'h3D;

    // Parity bits P0/P1 are appended above the six identifier bits.
    function automatic logic [7:0] lin_calc_pid(input logic [5:0] id6);
        logic p0;
        logic p1;
        p0 = id6[0] ^ id6[1] ^ id6[2] ^ id6[4];
        p1 = ~(id6[1] ^ id6[3] ^ id6[4] ^ id6[5]);
        return {p1, p0, id6};
    endfunction

    // A sum above 255 has 255 subtracted, which equals dropping the carry
    // bit and adding it back in at the bottom.
    function automatic logic [7:0] lin_chk_add(input logic [7:0] acc8, input logic [7:0] byte8);
        logic [8:0] sum9;
        sum9 = {1'b0, acc8} + {1'b0, byte8};
        return sum9[8] ? (sum9[7:0] + 8'd1) : sum9[7:0];
    endfunction

endpackage

// File: rtl/lin_bit_tick.sv
// -----------------------------------------------------------------------------
// lin_bit_tick
// Baud counter that divides the system clock down to LIN bit times.
//   i_clk      : system clock
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : synchronous restart of the count at zero
//   i_enable   : count while high, hold while low
//   o_bit_end  : high during the last clock cycle of every bit time
// -----------------------------------------------------------------------------
module lin_bit_tick #(
    parameter int CLK_DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Counts 0..CLK_DIV-1 and wraps, so every bit lasts exactly CLK_DIV cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/lin_frame_tx.sv
// -----------------------------------------------------------------------------
// lin_frame_tx
// LIN commander frame transmitter: break, delimiter, sync, protected ID,
// 1..MAX_BYTES data bytes and checksum, serialised on one wire.
//   i_sys_clk    : system clock
//   i_rstn       : asynchronous active-low reset
//   i_start      : single-cycle frame request, honoured only while idle
//   i_pid        : 6-bit frame identifier
//   i_data       : payload, byte 0 in bits [7:0] goes first
//   i_data_len   : number of payload bytes, 1..MAX_BYTES
//   i_chk_mode   : 0 classic checksum, 1 enhanced checksum
//   o_sdo        : serial output, recessive high
//   o_busy       : frame in progress
//   o_tx_done    : one-cycle pulse when the frame has finished
//   o_err_len    : one-cycle pulse when a start is refused for its length
//   o_frame_pid  : protected ID of the current or most recent frame
// -----------------------------------------------------------------------------
module lin_frame_tx
    import lin_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int BREAK_BITS = 13,
    parameter int MAX_BYTES  = 8
) (
    input  logic                   i_sys_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic [5:0]             i_pid,
    input  logic [8*MAX_BYTES-1:0] i_data,
    input  logic [3:0]             i_data_len,
    input  logic                   i_chk_mode,
    output logic                   o_sdo,
    output logic                   o_busy,
    output logic                   o_tx_done,
    output logic                   o_err_len,
    output logic [7:0]             o_frame_pid
);

    localparam logic [4:0] MAX_LEN    = 5'(MAX_BYTES);
    localparam logic [7:0] BREAK_LAST = 8'(BREAK_BITS - 1);

    lin_tx_state_t          r_state;
    logic [9:0]             r_shift;
    logic [7:0]             r_bitCnt;
    logic [3:0]             r_bytesLeft;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [7:0]             r_sum;
    logic [7:0]             r_framePid;
    logic                   r_busy;
    logic                   r_txDone;
    logic                   r_errLen;

    logic       w_bitEnd;
    logic       w_lenOk;
    logic       w_accept;
    logic       w_diagId;
    logic [7:0] w_pidCalc;

    assign w_pidCalc = lin_calc_pid(i_pid);
    assign w_lenOk   = (i_data_len != 4'd0) && ({1'b0, i_data_len} <= MAX_LEN);
    assign w_accept  = (r_state == IDLE) && i_start && w_lenOk;
    assign w_diagId  = (i_pid == DIAG_ID_MREQ) || (i_pid == DIAG_ID_SRESP);

    lin_bit_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_tick (
        .i_clk     (i_sys_clk),
        .i_rst_n   (i_rstn),
        .i_clear   (w_accept),
        .i_enable  (r_busy),
        .o_bit_end (w_bitEnd)
    );

    // Frame sequencer. r_shift[0] is the line itself: break loads all zeros,
    // idle/delimiter all ones, and a byte is loaded as {stop, data, start}
    // and shifted right with ones filling in behind.
    // The checksum starts at the PID for enhanced frames and at zero for
    // classic or diagnostic frames, then each data byte is added as it is
    // loaded, so the complete sum is ready when the last data byte ends.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= IDLE;
            r_shift     <= '1;
            r_bitCnt    <= '0;
            r_bytesLeft <= '0;
            r_data      <= '0;
            r_sum       <= '0;
            r_framePid  <= '0;
            r_busy      <= 1'b0;
            r_txDone    <= 1'b0;
            r_errLen    <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            r_errLen <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (!w_lenOk) begin
                            r_errLen <= 1'b1;
                        end else begin
                            r_state     <= BREAK;
                            r_busy      <= 1'b1;
                            r_shift     <= '0;
                            r_bitCnt    <= '0;
                            r_framePid  <= w_pidCalc;
                            r_data      <= i_data;
                            r_bytesLeft <= i_data_len;
                            r_sum       <= (i_chk_mode && !w_diagId) ? w_pidCalc : 8'h00;
                        end
                    end
                end
                BREAK: begin
                    if (w_bitEnd) begin
                        if (r_bitCnt == BREAK_LAST) begin
                            r_state  <= DELIM;
                            r_shift  <= '1;
                            r_bitCnt <= '0;
                        end else begin
                            r_bitCnt <= r_bitCnt + 8'd1;
                        end
                    end
                end
                DELIM: begin
                    if (w_bitEnd) begin
                        r_state  <= SYNC;
                        r_shift  <= {1'b1, SYNC_BYTE, 1'b0};
                        r_bitCnt <= '0;
                    end
                end
                default: begin
                    if (w_bitEnd) begin
                        if (r_bitCnt == 8'd9) begin
                            r_bitCnt <= '0;
                            case (r_state)
                                SYNC: begin
                                    r_state <= PID;
                                    r_shift <= {1'b1, r_framePid, 1'b0};
                                end
                                PID, DATA: begin
                                    if (r_state == DATA && r_bytesLeft == 4'd0) begin
                                        r_state <= CHK;
                                        r_shift <= {1'b1, ~r_sum, 1'b0};
                                    end else begin
                                        r_state     <= DATA;
                                        r_shift     <= {1'b1, r_data[7:0], 1'b0};
                                        r_data      <= r_data >> 8;
                                        r_sum       <= lin_chk_add(r_sum, r_data[7:0]);
                                        r_bytesLeft <= r_bytesLeft - 4'd1;
                                    end
                                end
                                default: begin
                                    r_state  <= IDLE;
                                    r_shift  <= '1;
                                    r_busy   <= 1'b0;
                                    r_txDone <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_bitCnt <= r_bitCnt + 8'd1;
                            r_shift  <= {1'b1, r_shift[9:1]};
                        end
                    end
                end
            endcase
        end
    end

    assign o_sdo       = r_shift[0];
    assign o_busy      = r_busy;
    assign o_tx_done   = r_txDone;
    assign o_err_len   = r_errLen;
    assign o_frame_pid = r_framePid;

endmodule

// File: tb/tb_lin_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_lin_frame_tx
// Directed bench for lin_frame_tx with CLK_DIV=10, BREAK_BITS=13, MAX_BYTES=8.
// send_frame drives one request and records the line cycle by cycle until
// tx_done; each test task then compares the decoded frame with hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_lin_frame_tx;

    localparam int CLK_DIV = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  pid = '0;
    logic [63:0] data = '0;
    logic [3:0]  dataLen = '0;
    logic        chkMode = 1'b0;
    logic        sdo;
    logic        busy;
    logic        txDone;
    logic        errLen;
    logic [7:0]  framePid;

    lin_frame_tx #(
        .CLK_DIV    (10),
        .BREAK_BITS (13),
        .MAX_BYTES  (8)
    ) dut (
        .i_sys_clk   (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_pid       (pid),
        .i_data      (data),
        .i_data_len  (dataLen),
        .i_chk_mode  (chkMode),
        .o_sdo       (sdo),
        .o_busy      (busy),
        .o_tx_done   (txDone),
        .o_err_len   (errLen),
        .o_frame_pid (framePid)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;

    logic       sdoQ[$];
    int         capCycles;
    int         capNBytes;
    logic       capDone;
    logic       capBusyAll;
    logic       capFirstSdo;
    logic       capFirstBusy;
    logic       capEndSdo;
    logic       capEndBusy;
    logic       capBreakOk;
    logic       capFramingOk;
    logic [7:0] capPid;
    logic [7:0] capBytes[11];

    // Requests a frame from the current cycle and records sdo each cycle
    // until tx_done. At pokeCycle a second start with different inputs is
    // raised mid-frame. Bits are decoded from the middle cycle of each bit.
    task automatic send_frame(input logic [5:0] p, input logic [63:0] d,
                              input logic [3:0] len, input logic mode,
                              input int pokeCycle);
        int nBits;
        int base;
        pid = p; data = d; dataLen = len; chkMode = mode; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        capFirstSdo = sdo; capFirstBusy = busy; capPid = framePid;
        sdoQ.delete();
        capBusyAll = 1'b1; capCycles = 0; capDone = 1'b0;
        capEndSdo = 1'bx; capEndBusy = 1'bx;
        for (int c = 1; c <= 2000; c++) begin
            if (txDone === 1'b1) begin
                capDone = 1'b1; capEndSdo = sdo; capEndBusy = busy;
                break;
            end
            sdoQ.push_back(sdo);
            if (busy !== 1'b1) capBusyAll = 1'b0;
            capCycles++;
            if (c == pokeCycle) begin
                start = 1'b1; pid = 6'h01; dataLen = 4'd1; data = '0; chkMode = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        capBreakOk = 1'b0; capFramingOk = 1'b0; capNBytes = 0;
        for (int j = 0; j < 11; j++) capBytes[j] = 8'hxx;
        nBits = sdoQ.size() / CLK_DIV;
        if (nBits >= 14) begin
            capBreakOk = 1'b1; capFramingOk = 1'b1;
            for (int b = 0; b < 13; b++) if (sdoQ[b*CLK_DIV+5] !== 1'b0) capBreakOk = 1'b0;
            if (sdoQ[13*CLK_DIV+5] !== 1'b1) capBreakOk = 1'b0;
            capNBytes = (nBits - 14) / 10;
            if (capNBytes > 11) capNBytes = 11;
            for (int j = 0; j < capNBytes; j++) begin
                base = 14 + 10*j;
                if (sdoQ[base*CLK_DIV+5] !== 1'b0) capFramingOk = 1'b0;
                for (int i = 0; i < 8; i++) capBytes[j][i] = sdoQ[(base+1+i)*CLK_DIV+5];
                if (sdoQ[(base+9)*CLK_DIV+5] !== 1'b1) capFramingOk = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (sdo !== 1'b1) $display("[TB] FAIL rst_sdo: got %b expected 1", sdo); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else nPass++;
        nChecks++; if (txDone !== 1'b0) $display("[TB] FAIL rst_tx_done: got %b expected 0", txDone); else nPass++;
        nChecks++; if (errLen !== 1'b0) $display("[TB] FAIL rst_err_len: got %b expected 0", errLen); else nPass++;
        nChecks++; if (framePid !== 8'h00) $display("[TB] FAIL rst_frame_pid: got %h expected 00", framePid); else nPass++;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_enhanced();
        logic [7:0] expB[5] = '{8'h55, 8'hAD, 8'h7F, 8'h7F, 8'h53};
        send_frame(6'h2D, 64'h7F7F, 4'd2, 1'b1, 0);
        nChecks++; if (capPid !== 8'hAD) $display("[TB] FAIL enh_frame_pid: got %h expected AD", capPid); else nPass++;
        nChecks++; if (capFirstSdo !== 1'b0 || capFirstBusy !== 1'b1) $display("[TB] FAIL enh_first_cycle: sdo=%b busy=%b expected sdo=0 busy=1", capFirstSdo, capFirstBusy); else nPass++;
        nChecks++; if (capDone !== 1'b1) $display("[TB] FAIL enh_done_seen: got %b expected 1", capDone); else nPass++;
        nChecks++; if (capCycles !== 640) $display("[TB] FAIL enh_length: got %0d cycles expected 640", capCycles); else nPass++;
        nChecks++; if (capBusyAll !== 1'b1) $display("[TB] FAIL enh_busy_held: got %b expected 1", capBusyAll); else nPass++;
        nChecks++; if (capBreakOk !== 1'b1 || capFramingOk !== 1'b1) $display("[TB] FAIL enh_framing: break=%b bytes=%b expected 1 1", capBreakOk, capFramingOk); else nPass++;
        nChecks++; if (capNBytes !== 5) $display("[TB] FAIL enh_byte_count: got %0d expected 5", capNBytes); else nPass++;
        for (int j = 0; j < 5; j++) begin
            nChecks++; if (capBytes[j] !== expB[j]) $display("[TB] FAIL enh_byte%0d: got %h expected %h", j, capBytes[j], expB[j]); else nPass++;
        end
        nChecks++; if (capEndSdo !== 1'b1 || capEndBusy !== 1'b0) $display("[TB] FAIL enh_end_state: sdo=%b busy=%b expected sdo=1 busy=0", capEndSdo, capEndBusy); else nPass++;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_diag_override();
        send_frame(6'h3C, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b1, 0);
        nChecks++; if (capPid !== 8'h3C) $display("[TB] FAIL diag_frame_pid: got %h expected 3C", capPid); else nPass++;
        nChecks++; if (capCycles !== 1240) $display("[TB] FAIL diag_length: got %0d cycles expected 1240", capCycles); else nPass++;
        nChecks++; if (capNBytes !== 11 || capFramingOk !== 1'b1) $display("[TB] FAIL diag_bytes: got %0d bytes framing=%b expected 11 1", capNBytes, capFramingOk); else nPass++;
        nChecks++; if (capBytes[1] !== 8'h3C) $display("[TB] FAIL diag_pid_byte: got %h expected 3C", capBytes[1]); else nPass++;
        nChecks++; if (capBytes[9] !== 8'hFF) $display("[TB] FAIL diag_last_data: got %h expected FF", capBytes[9]); else nPass++;
        nChecks++; if (capBytes[10] !== 8'h00) $display("[TB] FAIL diag_checksum: got %h expected 00", capBytes[10]); else nPass++;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_illegal_len();
        logic [3:0] lens[2] = '{4'd0, 4'd9};
        logic quiet;
        for (int t = 0; t < 2; t++) begin
            pid = 6'h2D; data = 64'h7F7F; dataLen = lens[t]; chkMode = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            nChecks++; if (errLen !== 1'b1) $display("[TB] FAIL len%0d_err_pulse: got %b expected 1", lens[t], errLen); else nPass++;
            nChecks++; if (busy !== 1'b0 || sdo !== 1'b1) $display("[TB] FAIL len%0d_no_start: busy=%b sdo=%b expected busy=0 sdo=1", lens[t], busy, sdo); else nPass++;
            @(posedge clk); #1;
            nChecks++; if (errLen !== 1'b0) $display("[TB] FAIL len%0d_err_single: got %b expected 0", lens[t], errLen); else nPass++;
            quiet = 1'b1;
            for (int c = 0; c < 30; c++) begin
                if (sdo !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
                @(posedge clk); #1;
            end
            nChecks++; if (quiet !== 1'b1) $display("[TB] FAIL len%0d_line_idle: got %b expected 1", lens[t], quiet); else nPass++;
        end
    endtask

    task automatic test_handshake();
        send_frame(6'h2D, 64'h7F7F, 4'd2, 1'b1, 100);
        nChecks++; if (capCycles !== 640) $display("[TB] FAIL hs_ignored_length: got %0d cycles expected 640", capCycles); else nPass++;
        nChecks++; if (capBytes[1] !== 8'hAD || capBytes[4] !== 8'h53) $display("[TB] FAIL hs_ignored_bytes: pid %h chk %h expected AD 53", capBytes[1], capBytes[4]); else nPass++;
        // Still in the tx_done cycle: the next request must be accepted here.
        send_frame(6'h2D, 64'h7F7F, 4'd2, 1'b0, 0);
        nChecks++; if (capFirstSdo !== 1'b0 || capFirstBusy !== 1'b1) $display("[TB] FAIL b2b_first_cycle: sdo=%b busy=%b expected sdo=0 busy=1", capFirstSdo, capFirstBusy); else nPass++;
        nChecks++; if (capCycles !== 640) $display("[TB] FAIL b2b_length: got %0d cycles expected 640", capCycles); else nPass++;
        nChecks++; if (capNBytes !== 5 || capBytes[2] !== 8'h7F) $display("[TB] FAIL b2b_bytes: got %0d bytes data0 %h expected 5 7F", capNBytes, capBytes[2]); else nPass++;
        nChecks++; if (capBytes[4] !== 8'h01) $display("[TB] FAIL classic_checksum: got %h expected 01", capBytes[4]); else nPass++;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        pid = 6'h2D; data = 64'h7F7F; dataLen = 4'd2; chkMode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Cycle 445 lies in the start bit of data byte 1 (bit 44).
        repeat (444) @(posedge clk);
        #1;
        nChecks++; if (sdo !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL mid_pre_reset: sdo=%b busy=%b expected sdo=0 busy=1", sdo, busy); else nPass++;
        #2 rstn = 1'b0;
        #1;
        nChecks++; if (sdo !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL mid_async_abort: sdo=%b busy=%b expected sdo=1 busy=0", sdo, busy); else nPass++;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame(6'h2D, 64'h7F7F, 4'd2, 1'b1, 0);
        nChecks++; if (capCycles !== 640 || capFramingOk !== 1'b1) $display("[TB] FAIL post_reset_frame: %0d cycles framing=%b expected 640 1", capCycles, capFramingOk); else nPass++;
        nChecks++; if (capBytes[3] !== 8'h7F || capBytes[4] !== 8'h53) $display("[TB] FAIL post_reset_bytes: data1 %h chk %h expected 7F 53", capBytes[3], capBytes[4]); else nPass++;
    endtask

    initial begin
        test_reset();
        test_enhanced();
        test_diag_override();
        test_illegal_len();
        test_handshake();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
